mem_access_unit: RTL

Stage-4 data-memory access unit of the ceres core: it takes a load or store from execute and issues one request on the data-memory handshake. It holds the pipeline stalled until the response returns, then aligns and extends the load data. Its registered `read_data_o` feeds the writeback stage's load-data input. Misaligned accesses and bus errors are reported as one-cycle exception pulses.

---
 rtl/ceres_param.sv | 26 ++
 rtl/load_formatter.sv | 43 ++++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ceres_param.sv
// Shared types and constants for the ceres core memory stage.
package ceres_param;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        DRAIN = 2'b11
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Size 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic result;
        unique case (size)
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = off[0];
            default:   result = (off != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Byte-lane helper: aligns/extends load data and builds store strobes and lanes.
module load_formatter
    import ceres_param::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rsp_data_i,
    input  logic [1:0]      byte_off_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted     = rsp_data_i >> {byte_off_i, 3'b000};
        load_data_o = shifted;
        wstrb_o     = 4'b1111;
        wdata_o     = wdata_i;
        unique case (size_i)
            SIZE_BYTE: begin
                load_data_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
                wstrb_o     = 4'b0001 << byte_off_i;
                wdata_o     = {4{wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                load_data_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
                wstrb_o     = 4'b0011 << byte_off_i;
                wdata_o     = {2{wdata_i[15:0]}};
            end
            default: begin
                load_data_o = shifted;
                wstrb_o     = 4'b1111;
                wdata_o     = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Stage-4 data-memory access unit: one request per access, stall until response,
// registered load data and one-cycle misaligned / access-fault pulses.
module mem_access_unit
    import ceres_param::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            ex_valid_i,
    input  logic            ex_we_i,
    input  logic [1:0]      ex_rw_size_i,
    input  logic            ex_unsigned_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    output logic            dmem_req_valid_o,
    input  logic            dmem_req_ready_i,
    output logic [XLEN-1:0] dmem_req_addr_o,
    output logic            dmem_req_we_o,
    output logic [3:0]      dmem_req_wstrb_o,
    output logic [XLEN-1:0] dmem_req_wdata_o,
    input  logic            dmem_rsp_valid_i,
    input  logic [XLEN-1:0] dmem_rsp_data_i,
    input  logic            dmem_rsp_err_i,
    output logic            mem_stall_o,
    output logic [XLEN-1:0] read_data_o,
    output logic            misaligned_o,
    output logic            access_fault_o
);

    mem_state_e state_q, state_d;

    logic [XLEN-1:0] req_addr_q, req_wdata_q;
    logic            req_we_q, req_unsigned_q;
    logic [1:0]      req_size_q;

    logic [XLEN-1:0] read_data_q;
    logic            misaligned_q, access_fault_q;

    logic            ex_misaligned, issue, complete, in_idle;
    logic [XLEN-1:0] sel_addr, sel_wdata;
    logic            sel_we, sel_unsigned;
    logic [1:0]      sel_size;
    logic [XLEN-1:0] fmt_load;
    logic [3:0]      fmt_wstrb;
    logic [XLEN-1:0] fmt_wdata;

    assign in_idle       = (state_q == IDLE);
    assign ex_misaligned = is_misaligned(ex_rw_size_i, ex_addr_i[1:0]);
    assign issue         = in_idle & ex_valid_i & ~ex_misaligned & ~flush_i;
    assign complete      = (state_q == WAIT) & dmem_rsp_valid_i & ~flush_i;

    // IDLE issues straight from execute; later states use the latched request.
    assign sel_addr     = in_idle ? ex_addr_i     : req_addr_q;
    assign sel_wdata    = in_idle ? ex_wdata_i    : req_wdata_q;
    assign sel_we       = in_idle ? ex_we_i       : req_we_q;
    assign sel_size     = in_idle ? ex_rw_size_i  : req_size_q;
    assign sel_unsigned = in_idle ? ex_unsigned_i : req_unsigned_q;

    load_formatter #(
        .XLEN (XLEN)
    ) u_load_formatter (
        .rsp_data_i  (dmem_rsp_data_i),
        .byte_off_i  (sel_addr[1:0]),
        .size_i      (sel_size),
        .unsigned_i  (sel_unsigned),
        .wdata_i     (sel_wdata),
        .load_data_o (fmt_load),
        .wstrb_o     (fmt_wstrb),
        .wdata_o     (fmt_wdata)
    );

    always_comb begin
        state_d          = state_q;
        dmem_req_valid_o = 1'b0;
        mem_stall_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    dmem_req_valid_o = 1'b1;
                    mem_stall_o      = 1'b1;
                    state_d          = dmem_req_ready_i ? WAIT : REQ;
                end
            end
            REQ: begin
                // Valid is held even under flush so an accepted store still lands.
                dmem_req_valid_o = 1'b1;
                mem_stall_o      = 1'b1;
                if (dmem_req_ready_i) begin
                    state_d = flush_i ? DRAIN : WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                mem_stall_o = ~dmem_rsp_valid_i;
                if (dmem_rsp_valid_i) begin
                    state_d = IDLE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mem_stall_o = ex_valid_i;
                if (dmem_rsp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req_addr_o  = {sel_addr[XLEN-1:2], 2'b00};
    assign dmem_req_we_o    = dmem_req_valid_o & sel_we;
    assign dmem_req_wstrb_o = (dmem_req_valid_o & sel_we) ? fmt_wstrb : 4'b0000;
    assign dmem_req_wdata_o = fmt_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_we_q       <= 1'b0;
            req_size_q     <= SIZE_BYTE;
            req_unsigned_q <= 1'b0;
            read_data_q    <= '0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            misaligned_q   <= in_idle & ex_valid_i & ex_misaligned & ~flush_i;
            access_fault_q <= complete & dmem_rsp_err_i;
            if (issue) begin
                req_addr_q     <= ex_addr_i;
                req_wdata_q    <= ex_wdata_i;
                req_we_q       <= ex_we_i;
                req_size_q     <= ex_rw_size_i;
                req_unsigned_q <= ex_unsigned_i;
            end
            if (complete && !req_we_q) begin
                read_data_q <= dmem_rsp_err_i ? '0 : fmt_load;
            end
        end
    end

    assign read_data_o    = read_data_q;
    assign misaligned_o   = misaligned_q;
    assign access_fault_o = access_fault_q;

endmodule
